byte_word_packer: RTL and testbench

//  Upstream feeder for the 16x16 word memory/FIFO. Accepts a byte stream over a

---
 rtl/packer_pkg.sv | 14 +
 rtl/sat_counter.sv | 23 ++
 rtl/byte_word_packer.sv | 97 +++++++++
 tb/tb_byte_word_packer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/packer_pkg.sv
// rtl/packer_pkg.sv - shared state encoding and widths for the byte-to-word packer
package packer_pkg;

    localparam int BYTE_W_DEF = 8;
    localparam int WORD_W = 2 * BYTE_W_DEF;
    localparam logic [7:0] DEFAULT_PAD = 8'h00;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_HALF  = 2'd1,
        ST_PEND  = 2'd2
    } state_t;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    // An increment landing on the clear edge belongs to the next frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= inc ? CNT_W'(1) : '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/byte_word_packer.sv
// rtl/byte_word_packer.sv - packs a handshaked byte stream into FIFO words with frame accounting
module byte_word_packer
    import packer_pkg::*;
#(
    parameter int                BYTE_W   = 8,
    parameter logic [BYTE_W-1:0] PAD      = BYTE_W'(DEFAULT_PAD),
    parameter bit                HI_FIRST = 1'b0,
    parameter int                CNT_W    = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic [BYTE_W-1:0]   in_byte,
    input  logic                in_last,
    output logic                in_ready,
    input  logic                fifo_full,
    output logic                fifo_w,
    output logic [2*BYTE_W-1:0] fifo_data,
    output logic                frame_done,
    output logic [CNT_W-1:0]    word_count
);

    state_t              state_q, state_d;
    logic [BYTE_W-1:0]   held_q, held_d;
    logic [2*BYTE_W-1:0] data_q, data_d;
    logic                last_q, last_d;
    logic                frame_done_q;
    logic                accept;

    function automatic logic [2*BYTE_W-1:0] pack_pair(input logic [BYTE_W-1:0] first,
                                                      input logic [BYTE_W-1:0] second);
        return HI_FIRST ? {first, second} : {second, first};
    endfunction

    assign fifo_w     = (state_q == ST_PEND) & ~fifo_full;
    assign in_ready   = ~rst & ((state_q != ST_PEND) | ~fifo_full);
    assign accept     = in_valid & in_ready;
    assign fifo_data  = data_q;
    assign frame_done = frame_done_q;

    always_comb begin
        state_d = state_q;
        held_d  = held_q;
        data_d  = data_q;
        last_d  = last_q;
        case (state_q)
            ST_HALF: begin
                if (accept) begin
                    data_d  = pack_pair(held_q, in_byte);
                    last_d  = in_last;
                    state_d = ST_PEND;
                end
            end
            default: begin
                // A pending word that drains this cycle frees the slot for a new first byte.
                if ((state_q != ST_PEND) || fifo_w) begin
                    state_d = ST_EMPTY;
                    if (accept) begin
                        held_d = in_byte;
                        if (in_last) begin
                            data_d  = pack_pair(in_byte, PAD);
                            last_d  = 1'b1;
                            state_d = ST_PEND;
                        end else begin
                            state_d = ST_HALF;
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_EMPTY;
            held_q       <= '0;
            data_q       <= '0;
            last_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            held_q       <= held_d;
            data_q       <= data_d;
            last_q       <= last_d;
            frame_done_q <= fifo_w & last_q;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_word_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (fifo_w),
        .clr   (frame_done_q),
        .count (word_count)
    );

endmodule

// File: tb/tb_byte_word_packer.sv
// tb/tb_byte_word_packer.sv - scoreboard bench for byte_word_packer, low- and high-first instances
module tb_byte_word_packer;

    typedef struct {
        logic [15:0] lo;
        logic [15:0] hi;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_byte = 8'h00;
    logic        in_last = 1'b0;
    logic        fifo_full = 1'b0;

    logic        in_ready, fifo_w, frame_done;
    logic [15:0] fifo_data;
    logic [4:0]  word_count;
    logic        in_ready_h, fifo_w_h, frame_done_h;
    logic [15:0] fifo_data_h;
    logic [4:0]  word_count_h;

    int   total = 0;
    int   bad = 0;
    exp_t exp_q[$];
    int   cnt_q[$];
    bit   rand_full = 1'b0;
    bit   bubble_mode = 1'b0;
    int   cyc = 0;
    int   prev_w = -1;

    byte_word_packer #(.BYTE_W(8), .PAD(8'h00), .HI_FIRST(1'b0), .CNT_W(5)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_byte(in_byte), .in_last(in_last),
        .in_ready(in_ready), .fifo_full(fifo_full), .fifo_w(fifo_w), .fifo_data(fifo_data),
        .frame_done(frame_done), .word_count(word_count)
    );

    byte_word_packer #(.BYTE_W(8), .PAD(8'h00), .HI_FIRST(1'b1), .CNT_W(5)) dut_hi (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_byte(in_byte), .in_last(in_last),
        .in_ready(in_ready_h), .fifo_full(fifo_full), .fifo_w(fifo_w_h), .fifo_data(fifo_data_h),
        .frame_done(frame_done_h), .word_count(word_count_h)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor: every write and every frame_done is matched against the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            check("fifo_w_match_hi", fifo_w_h, fifo_w);
            if (fifo_w) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("word_lo_first", fifo_data, e.lo);
                    check("word_hi_first", fifo_data_h, e.hi);
                end
                if (bubble_mode && prev_w >= 0) check("b2b_spacing", cyc - prev_w, 2);
                prev_w = cyc;
            end
            if (!bubble_mode) prev_w = -1;
            check("frame_done_match_hi", frame_done_h, frame_done);
            if (frame_done) begin
                if (cnt_q.size() == 0) begin
                    check("unexpected_frame_done", 1, 0);
                end else begin
                    int c;
                    c = cnt_q.pop_front();
                    check("final_word_count", word_count, c);
                    check("final_word_count_hi", word_count_h, c);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_full) fifo_full = ($urandom_range(0, 3) == 0);
    endtask

    // Reference model: pair bytes in arrival order, pad an odd tail only when the frame ends.
    task automatic push_frame(input logic [7:0] b[$], input bit has_last);
        int n, nw;
        int b0, b1;
        exp_t e;
        n  = b.size();
        nw = has_last ? (n + 1) / 2 : n / 2;
        for (int w = 0; w < nw; w++) begin
            b0 = int'(b[2*w]);
            b1 = (2*w + 1 < n) ? int'(b[2*w+1]) : 0;
            e.lo = 16'(b1 * 256 + b0);
            e.hi = 16'(b0 * 256 + b1);
            exp_q.push_back(e);
        end
        if (has_last) cnt_q.push_back(nw > 31 ? 31 : nw);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last);
        int   waited;
        logic acc;
        waited   = 0;
        acc      = 1'b0;
        in_valid = 1'b1;
        in_byte  = b;
        in_last  = last;
        while (!acc && waited < 300) begin
            @(negedge clk);
            acc = in_ready;
            tick();
            waited++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_byte  = 8'($urandom);
        if (!acc) check("byte_accept_timeout", 0, 1);
    endtask

    task automatic send_frame(input logic [7:0] b[$], input bit has_last, input bit gaps);
        for (int i = 0; i < b.size(); i++) begin
            send_byte(b[i], has_last && (i == b.size() - 1));
            if (gaps && $urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) tick();
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || cnt_q.size() != 0) && n < 3000) begin
            tick();
            n++;
        end
        check("drain_in_time", n < 3000, 1);
        repeat (2) tick();
    endtask

    initial begin
        logic [7:0] q[$];
        int         n;

        #12;
        check("rst_in_ready", in_ready, 0);
        check("rst_fifo_w", fifo_w, 0);
        check("rst_fifo_data", fifo_data, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_word_count", word_count, 0);
        tick();
        rst = 1'b0;
        tick();

        q = '{8'h34, 8'h12};
        push_frame(q, 1);
        send_frame(q, 1, 0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_done && n < 20);
        check("t2_frame_done_seen", frame_done, 1);
        @(negedge clk);
        check("t2_count_cleared", word_count, 0);
        tick();

        q = '{8'hAB};
        push_frame(q, 1);
        send_frame(q, 1, 0);
        drain();

        q.delete();
        for (int i = 0; i < 32; i++) q.push_back(8'(i));
        bubble_mode = 1'b1;
        push_frame(q, 1);
        send_frame(q, 1, 0);
        drain();
        bubble_mode = 1'b0;

        q = '{8'h11, 8'h22};
        push_frame(q, 1);
        send_byte(8'h11, 0);
        fifo_full = 1'b1;
        send_byte(8'h22, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_no_write", fifo_w, 0);
            check("stall_in_ready", in_ready, 0);
            check("stall_data_stable", fifo_data, 16'h2211);
            tick();
        end
        fifo_full = 1'b0;
        drain();

        q = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
        push_frame(q, 0);
        send_frame(q, 0, 0);
        send_byte(8'h55, 0);
        repeat (4) tick();
        @(negedge clk);
        check("mid_frame_count", word_count, 2);
        check("mid_frame_drained", exp_q.size(), 0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_fifo_w", fifo_w, 0);
        check("async_rst_fifo_data", fifo_data, 0);
        check("async_rst_frame_done", frame_done, 0);
        check("async_rst_word_count", word_count, 0);
        check("async_rst_in_ready", in_ready, 0);
        tick();
        tick();
        check("rst_held_in_ready", in_ready, 0);
        rst = 1'b0;
        tick();
        q = '{8'h01, 8'h02};
        push_frame(q, 1);
        send_frame(q, 1, 0);
        drain();

        rand_full = 1'b1;
        for (int f = 0; f < 12; f++) begin
            int len;
            len = (f == 5) ? 70 : $urandom_range(1, 40);
            q.delete();
            for (int i = 0; i < len; i++) q.push_back(8'($urandom));
            push_frame(q, 1);
            send_frame(q, 1, 1);
        end
        rand_full = 1'b0;
        fifo_full = 1'b0;
        drain();

        check("end_exp_queue_empty", exp_q.size(), 0);
        check("end_cnt_queue_empty", cnt_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
